// File: rtl/alu_writeback.sv
// ALU writeback: buffers ALU packets in an in-order FIFO and commits them to a 4x4 regfile and NZVC flags.
// Latency: a packet accepted at edge k commits at edge k+1 unless a load holds the write port.
// Backpressure: in_ready = !full; a head with wr_en stalls while mem_we claims the write port.
module alu_writeback #(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_result,
    input  logic [3:0] in_flags,
    input  logic [1:0] in_rd,
    input  logic       in_wr_en,
    input  logic       in_flag_en,
    input  logic       mem_we,
    input  logic [1:0] mem_rd,
    input  logic [3:0] mem_data,
    input  logic [1:0] ra_addr,
    input  logic [1:0] rb_addr,
    output logic [3:0] ra_data,
    output logic [3:0] rb_data,
    input  logic [3:0] cond,
    output logic       cond_true,
    output logic       cond_valid,
    output logic [3:0] flags,
    output logic       busy
);

    typedef struct packed {
        logic [3:0] result;
        logic [3:0] flags;
        logic [1:0] rd;
        logic       wr_en;
        logic       flag_en;
    } ent_t;

    ent_t             fifo_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [3:0]       regs [4];
    logic [3:0]       flags_q;

    ent_t head;
    logic full;
    logic push;
    logic pop;
    logic pend_flag;

    assign head = fifo_q[rd_ptr];
    assign full = (count == (PTR_W+1)'(DEPTH));
    assign push = in_valid && !full;
    // The load path owns the write port; only heads that actually write must yield.
    assign pop  = (count != '0) && !(mem_we && head.wr_en);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            flags_q <= '0;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr] <= '{result: in_result, flags: in_flags, rd: in_rd,
                                    wr_en: in_wr_en, flag_en: in_flag_en};
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
            if (mem_we) regs[mem_rd] <= mem_data;
            if (pop && head.wr_en)   regs[head.rd] <= head.result;
            if (pop && head.flag_en) flags_q <= head.flags;
        end
    end

    // Walk oldest to youngest so the youngest matching entry wins the bypass.
    always_comb begin : read_bypass
        logic [PTR_W-1:0] idx;
        ra_data   = regs[ra_addr];
        rb_data   = regs[rb_addr];
        pend_flag = 1'b0;
        idx       = '0;
        if (mem_we && mem_rd == ra_addr) ra_data = mem_data;
        if (mem_we && mem_rd == rb_addr) rb_data = mem_data;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if ((PTR_W+1)'(i) < count) begin
                if (fifo_q[idx].wr_en && fifo_q[idx].rd == ra_addr) ra_data = fifo_q[idx].result;
                if (fifo_q[idx].wr_en && fifo_q[idx].rd == rb_addr) rb_data = fifo_q[idx].result;
                if (fifo_q[idx].flag_en) pend_flag = 1'b1;
            end
        end
    end

    always_comb begin
        case (cond)
            4'b0000: cond_true = 1'b1;
            4'b0001: cond_true = flags_q[2];
            4'b0010: cond_true = !flags_q[2];
            4'b0011: cond_true = flags_q[0];
            4'b0100: cond_true = !flags_q[0];
            4'b0101: cond_true = flags_q[3];
            4'b0110: cond_true = !flags_q[3];
            4'b0111: cond_true = flags_q[1];
            4'b1000: cond_true = !flags_q[1];
            4'b1001: cond_true = flags_q[3] ^ flags_q[1];
            4'b1010: cond_true = !(flags_q[3] ^ flags_q[1]);
            default: cond_true = 1'b0;
        endcase
    end

    assign in_ready   = !full;
    assign busy       = (count != '0);
    assign cond_valid = !pend_flag;
    assign flags      = flags_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback (DEPTH=2): handshake, stalls, bypass, conditions, reset.
module tb_alu_writeback;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_result;
    logic [3:0] in_flags;
    logic [1:0] in_rd;
    logic       in_wr_en;
    logic       in_flag_en;
    logic       mem_we;
    logic [1:0] mem_rd;
    logic [3:0] mem_data;
    logic [1:0] ra_addr;
    logic [1:0] rb_addr;
    logic [3:0] ra_data;
    logic [3:0] rb_data;
    logic [3:0] cond;
    logic       cond_true;
    logic       cond_valid;
    logic [3:0] flags;
    logic       busy;

    int tests  = 0;
    int failed = 0;

    alu_writeback #(.DEPTH(2), .PTR_W(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_flags(in_flags), .in_rd(in_rd),
        .in_wr_en(in_wr_en), .in_flag_en(in_flag_en),
        .mem_we(mem_we), .mem_rd(mem_rd), .mem_data(mem_data),
        .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra_data), .rb_data(rb_data),
        .cond(cond), .cond_true(cond_true), .cond_valid(cond_valid),
        .flags(flags), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge, then let inputs/combinational outputs settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pkt(input logic v, input logic [3:0] res, input logic [3:0] fl,
                       input logic [1:0] rd, input logic we, input logic fe);
        in_valid   = v;
        in_result  = res;
        in_flags   = fl;
        in_rd      = rd;
        in_wr_en   = we;
        in_flag_en = fe;
    endtask

    task automatic mem(input logic we, input logic [1:0] rd, input logic [3:0] d);
        mem_we   = we;
        mem_rd   = rd;
        mem_data = d;
    endtask

    initial begin
        rst = 1'b1;
        pkt(0, 4'h0, 4'h0, 2'd0, 0, 0);
        mem(0, 2'd0, 4'h0);
        ra_addr = 2'd0;
        rb_addr = 2'd3;
        cond    = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_cond_valid", cond_valid, 1);
        chk("rst_flags", flags, 4'h0);
        chk("rst_r0", ra_data, 4'h0);
        chk("rst_r3", rb_data, 4'h0);

        // Single packet: r2 <= 0101, flags <= 0000
        pkt(1, 4'b0101, 4'b0000, 2'd2, 1, 1);
        ra_addr = 2'd2;
        #1;
        chk("single_pre_r2", ra_data, 4'h0);
        tick();
        pkt(0, 4'h0, 4'h0, 2'd0, 0, 0);
        #1;
        chk("single_busy", busy, 1);
        chk("single_cond_valid", cond_valid, 0);
        chk("single_bypass_r2", ra_data, 4'b0101);
        tick();
        chk("single_done_busy", busy, 0);
        chk("single_done_cv", cond_valid, 1);
        chk("single_r2", ra_data, 4'b0101);
        chk("single_flags", flags, 4'b0000);

        // Load holds the port for 3 cycles while three packets target r0
        mem(1, 2'd1, 4'b1010);
        ra_addr = 2'd0;
        pkt(1, 4'h1, 4'h0, 2'd0, 1, 0);
        #1;
        chk("fill_rdy0", in_ready, 1);
        tick();
        pkt(1, 4'h2, 4'h0, 2'd0, 1, 0);
        #1;
        chk("fill_rdy1", in_ready, 1);
        tick();
        pkt(1, 4'h3, 4'h0, 2'd0, 1, 0);
        #1;
        chk("fill_full", in_ready, 0);
        chk("fill_bypass_r0", ra_data, 4'h2);
        tick();
        mem(0, 2'd0, 4'h0);
        #1;
        chk("stall_still_full", in_ready, 0);
        tick();
        chk("drain_rdy", in_ready, 1);
        chk("drain_bypass_r0", ra_data, 4'h2);
        tick();
        pkt(0, 4'h0, 4'h0, 2'd0, 0, 0);
        #1;
        chk("drain_last_bypass", ra_data, 4'h3);
        chk("drain_last_busy", busy, 1);
        tick();
        rb_addr = 2'd1;
        #1;
        chk("drain_empty", busy, 0);
        chk("drain_r0", ra_data, 4'h3);
        chk("drain_r1_mem", rb_data, 4'b1010);

        // Same-cycle load r3=1111 and ALU packet r3=0001
        ra_addr = 2'd3;
        mem(1, 2'd3, 4'b1111);
        pkt(1, 4'b0001, 4'h0, 2'd3, 1, 0);
        #1;
        chk("memfwd_r3", ra_data, 4'b1111);
        tick();
        pkt(0, 4'h0, 4'h0, 2'd0, 0, 0);
        mem(1, 2'd3, 4'b0111);
        #1;
        chk("fifo_beats_mem", ra_data, 4'b0001);
        tick();
        mem(0, 2'd0, 4'h0);
        #1;
        chk("waw_stalled_busy", busy, 1);
        tick();
        chk("waw_busy", busy, 0);
        chk("waw_r3", ra_data, 4'b0001);

        // Flags 1001
        pkt(1, 4'h0, 4'b1001, 2'd0, 0, 1);
        tick();
        pkt(0, 4'h0, 4'h0, 2'd0, 0, 0);
        #1;
        chk("flag_pending_cv", cond_valid, 0);
        tick();
        chk("flags_1001", flags, 4'b1001);
        chk("flags_cv", cond_valid, 1);
        cond = 4'b1001; #1; chk("cond_lt", cond_true, 1);
        cond = 4'b1010; #1; chk("cond_ge", cond_true, 0);
        cond = 4'b0101; #1; chk("cond_mi", cond_true, 1);
        cond = 4'b0001; #1; chk("cond_eq", cond_true, 0);
        cond = 4'b1100; #1; chk("cond_rsvd", cond_true, 0);
        cond = 4'b0000; #1; chk("cond_al", cond_true, 1);
        cond = 4'b0011; #1; chk("cond_cs", cond_true, 1);
        cond = 4'b1000; #1; chk("cond_vc", cond_true, 1);

        // Flags 0100
        pkt(1, 4'h0, 4'b0100, 2'd0, 0, 1);
        tick();
        pkt(0, 4'h0, 4'h0, 2'd0, 0, 0);
        tick();
        chk("flags_0100", flags, 4'b0100);
        cond = 4'b0001; #1; chk("cond_eq2", cond_true, 1);
        cond = 4'b0010; #1; chk("cond_ne2", cond_true, 0);

        // Reset with two pending packets
        mem(1, 2'd0, 4'h0);
        pkt(1, 4'h6, 4'h0, 2'd1, 1, 0);
        tick();
        pkt(1, 4'h7, 4'hF, 2'd2, 1, 1);
        tick();
        pkt(0, 4'h0, 4'h0, 2'd0, 0, 0);
        mem(0, 2'd0, 4'h0);
        #1;
        chk("pre_rst_full", in_ready, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ra_addr = 2'd1;
        rb_addr = 2'd2;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rdy", in_ready, 1);
        chk("mid_rst_cv", cond_valid, 1);
        chk("mid_rst_flags", flags, 4'h0);
        chk("mid_rst_r1", ra_data, 4'h0);
        chk("mid_rst_r2", rb_data, 4'h0);
        tick();
        tick();
        chk("post_rst_r1", ra_data, 4'h0);
        chk("post_rst_r2", rb_data, 4'h0);
        chk("post_rst_flags", flags, 4'h0);

        // Flag-only packet retires alongside a load
        pkt(1, 4'h5, 4'b0110, 2'd0, 0, 1);
        tick();
        pkt(0, 4'h0, 4'h0, 2'd0, 0, 0);
        mem(1, 2'd2, 4'hC);
        tick();
        mem(0, 2'd0, 4'h0);
        ra_addr = 2'd0;
        #1;
        chk("flagonly_busy", busy, 0);
        chk("flagonly_flags", flags, 4'b0110);
        chk("flagonly_mem_r2", rb_data, 4'hC);
        chk("flagonly_r0", ra_data, 4'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Downstream stage of the 4-bit ALU.
- Accepts ALU result/flag packets through a valid/ready handshake and buffers them in a small in-order FIFO.
- Commits each packet to a 4x4-bit register file and the NZVC flag register, sharing the single register-file write port with the memory-load path, which has priority.
- Provides two combinational read ports with FIFO bypass, plus branch-condition evaluation.

Parameters:
- DEPTH, 2, FIFO entries; legal values 2 or 4.
- PTR_W, 1, log2(DEPTH); must match DEPTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  ALU packet present.
- in_ready  out  1  stage can accept; equals !full.
- in_result  in  4  ALU result.
- in_flags  in  4  ALU flags {N,Z,V,C}.
- in_rd  in  2  destination register.
- in_wr_en  in  1  packet writes in_rd.
- in_flag_en  in  1  packet updates the flag register.
- mem_we  in  1  load-path write request; always accepted.
- mem_rd  in  2  load destination.
- mem_data  in  4  load data.
- ra_addr, rb_addr  in  2 each  read addresses.
- ra_data, rb_data  out  4 each  read data, combinational.
- cond  in  4  condition code.
- cond_true  out  1  condition result.
- cond_valid  out  1  no flag-updating packet pending in the FIFO.
- flags  out  4  committed {N,Z,V,C}.
- busy  out  1  FIFO non-empty.

Behaviour:
- Reset (synchronous, active-high):
  - FIFO empty, pointers 0, count 0.
  - All registers 0; flags = 0000.
  - in_ready = 1, busy = 0, cond_valid = 1.
  - Reset has priority over every other input, including mid-drain; all pending packets are discarded.
- Enqueue: a packet is accepted when in_valid && in_ready at the clock edge. Packets with in_wr_en = 0 and in_flag_en = 0 are still enqueued, so ordering is preserved.
- Commit:
  - Each cycle the FIFO head retires unless mem_we = 1 and the head has wr_en = 1. In that case the head stalls one cycle and the memory write takes the port.
  - A head with wr_en = 0 retires even while mem_we = 1.
  - On retirement: regfile[rd] <= result if wr_en; flags <= head flags if flag_en.
  - Minimum latency: packet accepted at edge k is committed at edge k+1.
- Simultaneous enqueue and retire while full: not possible (in_ready = 0). When non-full, enqueue and retire in the same cycle leave count unchanged.
- Pointers wrap modulo DEPTH. Count ranges 0..DEPTH; full = (count == DEPTH).
- Memory write and a pending FIFO write to the same register: the memory write lands first, and the later FIFO commit overwrites it (program order is ALU-after-load).
- Reads, combinational:
  - Source is the youngest FIFO entry with wr_en = 1 and rd == addr.
  - Otherwise, mem_data if mem_we and mem_rd == addr.
  - Otherwise, the register file.
- Conditions, from committed flags only:
  - 0000 always
  - 0001 EQ (Z)
  - 0010 NE (!Z)
  - 0011 CS (C)
  - 0100 CC (!C)
  - 0101 MI (N)
  - 0110 PL (!N)
  - 0111 VS (V)
  - 1000 VC (!V)
  - 1001 LT (N^V)
  - 1010 GE (!(N^V))
  - 1011..1111: cond_true = 0
- cond_valid = 0 while any FIFO entry has flag_en = 1. The consumer must not act on cond_true while cond_valid = 0.
- No X may propagate to outputs from an empty FIFO; head fields are ignored when count = 0.

Test Plan:
- Reset then single packet (result=0101, flags=0000, rd=2, wr_en=1, flag_en=1) -> next edge r2=0101, flags=0000; cycle after enqueue: busy=1, cond_valid=0, ra_addr=2 reads 0101 via bypass.
- Hold mem_we=1 (rd=1) for 3 cycles while sending 3 packets with wr_en=1 -> FIFO fills at DEPTH=2, in_ready=0 on the third; after mem_we drops, packets commit in order and in_ready returns to 1.
- mem write r3=1111, then same-cycle ALU packet to r3=0001 enqueued -> after drain r3=0001; in between, the ra_addr=3 read returns 0001 (FIFO bypass beats mem).
- Flags 1001 committed -> LT true, GE false, MI true, EQ false, cond=1100 false; flags 0100 -> EQ true, NE false.
- Reset asserted with 2 packets pending -> after the edge: count=0, registers 0, flags 0000, pending writes never occur.
- Packet with wr_en=0, flag_en=1 during mem_we=1 -> retires immediately, flags updated, mem write also committed.
